// File: rtl/md_pkg.sv
// Shared multiply/divide encodings, also used by the D-stage decoder.
// MD_DIV_EN selects whether DIV/DIVU are real multi-cycle ops.
package md_pkg;

   localparam int MD_CNT_W = 4;

   localparam logic [2:0] MD_MULT  = 3'd0;
   localparam logic [2:0] MD_MULTU = 3'd1;
   localparam logic [2:0] MD_DIV   = 3'd2;
   localparam logic [2:0] MD_DIVU  = 3'd3;
   localparam logic [2:0] MD_MTHI  = 3'd4;
   localparam logic [2:0] MD_MTLO  = 3'd5;

   typedef enum logic {
      MD_IDLE = 1'b0,
      MD_RUN  = 1'b1
   } md_state_e;

   // Ops that occupy the unit for several cycles and therefore stall Decode.
   function automatic logic md_is_long(input logic [2:0] op);
`ifdef MD_DIV_EN
      return op <= MD_DIVU;
`else
      return op <= MD_MULTU;
`endif
   endfunction

endpackage

// File: rtl/md_calc.sv
// Combinational multiply/divide datapath: {hi,lo} result plus divide-by-zero flag.
// The divider exists only when MD_DIV_EN is defined.
module md_calc
   import md_pkg::*;
(
   input  logic [1:0]  op_i,
   input  logic [31:0] a_i,
   input  logic [31:0] b_i,
   output logic [63:0] res_o,
   output logic        div_zero_o
);

   logic        sgn;
   logic [63:0] a64, b64, mul_res;

   // op[0]=0 selects the signed flavour for both MULT and DIV.
   assign sgn = ~op_i[0];

   // Sign-extend then multiply modulo 2^64; the true product always fits.
   assign a64     = {{32{sgn & a_i[31]}}, a_i};
   assign b64     = {{32{sgn & b_i[31]}}, b_i};
   assign mul_res = a64 * b64;

`ifdef MD_DIV_EN
   logic        a_neg, b_neg, b_zero;
   logic [31:0] a_mag, b_mag, q_mag, r_mag, quo, rem;

   assign a_neg  = sgn & a_i[31];
   assign b_neg  = sgn & b_i[31];
   assign b_zero = (b_i == 32'd0);

   // 0x80000000 stays 0x80000000 as a magnitude, so the overflow case
   // naturally yields lo=0x80000000, hi=0.
   assign a_mag = a_neg ? (~a_i + 32'd1) : a_i;
   assign b_mag = b_neg ? (~b_i + 32'd1) : b_i;
   assign q_mag = b_zero ? 32'd0 : (a_mag / b_mag);
   assign r_mag = b_zero ? 32'd0 : (a_mag % b_mag);

   assign quo = (a_neg ^ b_neg) ? (~q_mag + 32'd1) : q_mag;
   assign rem = a_neg ? (~r_mag + 32'd1) : r_mag;

   assign res_o      = op_i[1] ? {rem, quo} : mul_res;
   assign div_zero_o = op_i[1] & b_zero;
`else
   assign res_o      = op_i[1] ? 64'd0 : mul_res;
   assign div_zero_o = 1'b0;
`endif

endmodule

// File: rtl/e_md_unit.sv
// E-stage multiply/divide unit: owns HI/LO, runs a busy counter, commits on 1->0.
// Divide support is enabled by defining MD_DIV_EN.
module e_md_unit
   import md_pkg::*;
#(
   parameter int MULT_CYCLES = 5,
   parameter int DIV_CYCLES  = 10
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [2:0]  op,
   input  logic [31:0] a,
   input  logic [31:0] b,
   output logic        busy,
   output logic        stall_req,
   output logic [31:0] hi,
   output logic [31:0] lo
);

   localparam logic [MD_CNT_W-1:0] MULT_CNT = MD_CNT_W'(MULT_CYCLES);
   localparam logic [MD_CNT_W-1:0] DIV_CNT  = MD_CNT_W'(DIV_CYCLES);

   md_state_e           state_q;
   logic [MD_CNT_W-1:0] cnt_q, cnt_d;
   logic                busy_q;
   logic [63:0]         pend_q;
   logic                pend_wr_q;
   logic [31:0]         hi_q, lo_q;

   logic [63:0]         calc_res;
   logic                calc_dz;
   logic                long_op;

   md_calc u_calc (
      .op_i       (op[1:0]),
      .a_i        (a),
      .b_i        (b),
      .res_o      (calc_res),
      .div_zero_o (calc_dz)
   );

   assign long_op = md_is_long(op);
   assign cnt_d   = cnt_q - 1'b1;

   // Result is latched at capture; HI/LO only change on the final count edge,
   // and a divide by zero suppresses that write entirely.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= MD_IDLE;
         cnt_q     <= '0;
         busy_q    <= 1'b0;
         pend_q    <= '0;
         pend_wr_q <= 1'b0;
         hi_q      <= '0;
         lo_q      <= '0;
      end else begin
         case (state_q)
            MD_IDLE: begin
               if (start) begin
                  if (long_op) begin
                     state_q   <= MD_RUN;
                     busy_q    <= 1'b1;
                     cnt_q     <= op[1] ? DIV_CNT : MULT_CNT;
                     pend_q    <= calc_res;
                     pend_wr_q <= ~calc_dz;
                  end else if (op == MD_MTHI) begin
                     hi_q <= a;
                  end else if (op == MD_MTLO) begin
                     lo_q <= a;
                  end
               end
            end
            MD_RUN: begin
               cnt_q <= cnt_d;
               if (cnt_q == MD_CNT_W'(1)) begin
                  state_q <= MD_IDLE;
                  busy_q  <= 1'b0;
                  if (pend_wr_q) {hi_q, lo_q} <= pend_q;
               end
            end
            default: begin
               state_q <= MD_IDLE;
               cnt_q   <= '0;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   assign busy      = busy_q;
   assign stall_req = busy_q | (start & long_op);
   assign hi        = hi_q;
   assign lo        = lo_q;

endmodule

// File: tb/tb_e_md_unit.sv
// Self-checking bench for e_md_unit: vector table plus scoreboard queue,
// and hand sequences for busy-time MTLO and mid-run reset.
module tb_e_md_unit;

   logic        clk = 1'b0;
   logic        reset, start;
   logic [2:0]  op;
   logic [31:0] a, b;
   logic        busy, stall_req;
   logic [31:0] hi, lo;

   int checks = 0;
   int errors = 0;

   e_md_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
      .clk       (clk),
      .reset     (reset),
      .start     (start),
      .op        (op),
      .a         (a),
      .b         (b),
      .busy      (busy),
      .stall_req (stall_req),
      .hi        (hi),
      .lo        (lo)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [2:0]  op;
      logic [31:0] a, b;
      bit          khi, klo;
      logic [31:0] ehi, elo;
      int          ncyc;
   } vec_t;

   typedef struct {
      logic [31:0] hi, lo;
      int          ncyc;
   } exp_t;

   vec_t vecs[$];
   exp_t sb[$];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   function automatic vec_t mk(input logic [2:0] o, input logic [31:0] va, input logic [31:0] vb,
                               input bit khi, input bit klo, input logic [31:0] ehi,
                               input logic [31:0] elo, input int n);
      vec_t v;
      v.op = o; v.a = va; v.b = vb; v.khi = khi; v.klo = klo;
      v.ehi = ehi; v.elo = elo; v.ncyc = n;
      return v;
   endfunction

   // Divide vectors collapse to a held no-op when the divider is compiled out.
   function automatic vec_t mkdiv(input logic [2:0] o, input logic [31:0] va, input logic [31:0] vb,
                                  input bit keep, input logic [31:0] ehi, input logic [31:0] elo);
`ifdef MD_DIV_EN
      return mk(o, va, vb, keep, keep, ehi, elo, 10);
`else
      return mk(o, va, vb, 1'b1, 1'b1, ehi, elo, 0);
`endif
   endfunction

   task automatic run_vec(input vec_t v, input string name);
      logic [31:0] h0, l0;
      exp_t        e;
      int          n;
      bit          hold_ok, stall_ok;
      h0 = hi; l0 = lo;
      e.hi   = v.khi ? h0 : v.ehi;
      e.lo   = v.klo ? l0 : v.elo;
      e.ncyc = v.ncyc;
      sb.push_back(e);
      op = v.op; a = v.a; b = v.b; start = 1'b1;
      #1;
      chk({name, "_stall_req"}, {63'd0, stall_req}, {63'd0, v.ncyc != 0});
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      n = 0; hold_ok = 1'b1; stall_ok = 1'b1;
      while (busy && n < 40) begin
         n++;
         if (hi !== h0 || lo !== l0) hold_ok = 1'b0;
         if (stall_req !== 1'b1) stall_ok = 1'b0;
         @(negedge clk);
      end
      e = sb.pop_front();
      chk({name, "_cycles"}, 64'(n), 64'(e.ncyc));
      chk({name, "_hold"}, {63'd0, hold_ok}, 64'd1);
      chk({name, "_stall_busy"}, {63'd0, stall_ok}, 64'd1);
      chk({name, "_hilo"}, {hi, lo}, {e.hi, e.lo});
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "timeout");
   end

   initial begin
      int n;
      reset = 1'b1; start = 1'b0; op = 3'd7; a = '0; b = '0;

      vecs.push_back(mk(3'd4, 32'h11, 0, 0, 1, 32'h11, 0, 0));
      vecs.push_back(mk(3'd5, 32'h22, 0, 1, 0, 0, 32'h22, 0));
      vecs.push_back(mk(3'd0, 32'hFFFFFFFE, 32'd3, 0, 0, 32'hFFFFFFFF, 32'hFFFFFFFA, 5));
      vecs.push_back(mk(3'd1, 32'hFFFFFFFF, 32'd2, 0, 0, 32'h00000001, 32'hFFFFFFFE, 5));
      vecs.push_back(mk(3'd0, 32'h80000000, 32'h80000000, 0, 0, 32'h40000000, 32'h0, 5));
      vecs.push_back(mk(3'd0, 32'd7, 32'hFFFFFFFB, 0, 0, 32'hFFFFFFFF, 32'hFFFFFFDD, 5));
      vecs.push_back(mk(3'd1, 32'h00010000, 32'h00010000, 0, 0, 32'h1, 32'h0, 5));
      vecs.push_back(mk(3'd6, 32'h1234, 32'h5678, 1, 1, 0, 0, 0));
      vecs.push_back(mk(3'd4, 32'h11, 0, 0, 1, 32'h11, 0, 0));
      vecs.push_back(mk(3'd5, 32'h22, 0, 1, 0, 0, 32'h22, 0));
      vecs.push_back(mkdiv(3'd3, 32'h1234, 32'h0, 1, 0, 0));
      vecs.push_back(mkdiv(3'd2, 32'hFFFFFFF9, 32'd2, 0, 32'hFFFFFFFF, 32'hFFFFFFFD));
      vecs.push_back(mkdiv(3'd2, 32'd7, 32'hFFFFFFFE, 0, 32'h1, 32'hFFFFFFFD));
      vecs.push_back(mkdiv(3'd2, 32'h80000000, 32'hFFFFFFFF, 0, 32'h0, 32'h80000000));
      vecs.push_back(mkdiv(3'd3, 32'hFFFFFFFF, 32'h10, 0, 32'hF, 32'h0FFFFFFF));
      vecs.push_back(mkdiv(3'd3, 32'd100, 32'd7, 0, 32'd2, 32'd14));

      repeat (3) @(negedge clk);
      reset = 1'b0;
      chk("reset_busy", {63'd0, busy}, 64'd0);
      chk("reset_hilo", {hi, lo}, 64'd0);
      chk("reset_stall", {63'd0, stall_req}, 64'd0);

      // Back-to-back: each vector starts on the cycle its predecessor finished.
      for (int i = 0; i < vecs.size(); i++)
         run_vec(vecs[i], $sformatf("vec%0d", i));

      // MTLO while busy must be ignored.
      op = 3'd0; a = 32'hFFFFFFFE; b = 32'd3; start = 1'b1;
      @(posedge clk); @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      op = 3'd5; a = 32'h55; start = 1'b1;
      #1;
      chk("mtlo_busy_stall", {63'd0, stall_req}, 64'd1);
      @(posedge clk); @(negedge clk);
      start = 1'b0;
      n = 0;
      while (busy && n < 40) begin n++; @(negedge clk); end
      chk("mtlo_busy_hilo", {hi, lo}, {32'hFFFFFFFF, 32'hFFFFFFFA});
      run_vec(mk(3'd4, 32'hAA, 0, 0, 1, 32'hAA, 0, 0), "mthi_idle");

      // Reset in the third busy cycle discards the pending result.
`ifdef MD_DIV_EN
      op = 3'd2;
`else
      op = 3'd0;
`endif
      a = 32'd100; b = 32'd7; start = 1'b1;
      @(posedge clk); @(negedge clk);
      start = 1'b0;
      repeat (2) @(negedge clk);
      chk("rst_mid_busy_before", {63'd0, busy}, 64'd1);
      reset = 1'b1;
      @(posedge clk); @(negedge clk);
      reset = 1'b0;
      chk("rst_mid_busy", {63'd0, busy}, 64'd0);
      chk("rst_mid_hilo", {hi, lo}, 64'd0);
      repeat (15) @(negedge clk);
      chk("rst_no_commit_busy", {63'd0, busy}, 64'd0);
      chk("rst_no_commit_hilo", {hi, lo}, 64'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
